// File: rtl/rank_arb_pkg.sv
// Shared types and encodings for the rank owner arbiter.
// Imported by the arbiter top and its starvation counter.
package rank_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOST_OWN = 2'd1,
        NMT_OWN  = 2'd2,
        TURN     = 2'd3
    } arb_state_e;

    localparam logic [1:0] NMT_WRITE  = 2'b00;
    localparam logic [1:0] NMT_READ   = 2'b01;
    localparam logic       HOST_READ  = 1'b0;
    localparam logic       HOST_WRITE = 1'b1;
    localparam logic       OWNER_HOST = 1'b0;
    localparam logic       OWNER_NMT  = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
        logic write;
    } rank_cmd_t;

    // Only the exact WRITE code is a write; every other NMT code reads.
    function automatic logic nmt_is_write(input logic [1:0] op);
        return op == NMT_WRITE;
    endfunction

endpackage

// File: rtl/rank_starve_counter.sv
// Saturating wait counter for a pending requester.
// Clear wins over increment; the count never passes LIMIT.
module rank_starve_counter
    import rank_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, else increment until the limit is reached.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != LIMIT_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == LIMIT_V);

endmodule

// File: rtl/rank_owner_arbiter.sv
// Arbitrates one DRAM rank between the host and the NMT engine,
// inserting turnaround gaps on owner changes and bounding NMT waits.
module rank_owner_arbiter
    import rank_arb_pkg::*;
#(
    parameter int TURNAROUND_CYC = 2,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_req_valid,
    input  logic       host_req_op,
    output logic       host_req_ready,
    input  logic       nmt_req_valid,
    input  logic [1:0] nmt_req_op,
    output logic       nmt_req_ready,
    input  logic       rank_busy,
    output logic       rank_cmd_valid,
    output logic       rank_cmd_owner,
    output logic       rank_cmd_write,
    output logic       context_switch,
    output logic [3:0] starve_count
);

    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND_CYC - 1);

    arb_state_e state_q, state_d;
    logic       target_q, target_d;
    logic       last_owner_q, last_owner_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    logic       nmt_seen_q, nmt_seen_d;
    logic       last_nmt_wr_q, last_nmt_wr_d;
    logic       cs_q, cs_d;
    rank_cmd_t  cmd_q, cmd_d;

    logic host_acc;
    logic nmt_acc;
    logic starve_hit;
    logic at_limit;
    logic nmt_wr_eff;
    logic pick_valid;
    logic pick_owner;

    assign host_req_ready = (state_q == HOST_OWN) & ~rank_busy;
    assign nmt_req_ready  = (state_q == NMT_OWN) & ~rank_busy;
    assign host_acc       = host_req_valid & host_req_ready;
    assign nmt_acc        = nmt_req_valid & nmt_req_ready;
    assign starve_hit     = nmt_req_valid & at_limit;

    rank_starve_counter #(
        .WIDTH (4),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (nmt_req_valid & ~nmt_acc),
        .clr      (~nmt_req_valid | nmt_acc),
        .count    (starve_count),
        .at_limit (at_limit)
    );

    // Owner choice from IDLE: starved NMT, then host, then NMT.
    always_comb begin
        pick_valid = 1'b1;
        pick_owner = OWNER_HOST;
        if (starve_hit) begin
            pick_owner = OWNER_NMT;
        end else if (host_req_valid) begin
            pick_owner = OWNER_HOST;
        end else if (nmt_req_valid) begin
            pick_owner = OWNER_NMT;
        end else begin
            pick_valid = 1'b0;
        end
    end

    // Ownership FSM next state plus command and predictor outputs.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        last_owner_d  = last_owner_q;
        turn_cnt_d    = '0;
        cs_d          = 1'b0;
        nmt_wr_eff    = nmt_acc ? nmt_is_write(nmt_req_op) : last_nmt_wr_q;
        last_nmt_wr_d = nmt_wr_eff;

        cmd_d.valid = host_acc | nmt_acc;
        cmd_d.owner = nmt_acc ? OWNER_NMT : OWNER_HOST;
        cmd_d.write = nmt_acc ? nmt_is_write(nmt_req_op)
                              : (host_acc & (host_req_op == HOST_WRITE));

        unique case (state_q)
            IDLE: begin
                if (!rank_busy && pick_valid) begin
                    if (pick_owner == last_owner_q) begin
                        state_d = (pick_owner == OWNER_NMT) ? NMT_OWN
                                                            : HOST_OWN;
                    end else begin
                        state_d  = TURN;
                        target_d = pick_owner;
                    end
                end
            end
            HOST_OWN: begin
                if (!rank_busy) begin
                    if (starve_hit || (!host_req_valid && nmt_req_valid)) begin
                        state_d  = TURN;
                        target_d = OWNER_NMT;
                    end else if (!host_req_valid) begin
                        state_d = IDLE;
                    end
                end
            end
            NMT_OWN: begin
                if (!rank_busy) begin
                    if (host_req_valid && (nmt_seen_q || nmt_acc)) begin
                        state_d  = TURN;
                        target_d = OWNER_HOST;
                        cs_d     = (host_req_op == HOST_READ) & nmt_wr_eff;
                    end else if (!nmt_req_valid) begin
                        state_d = IDLE;
                    end
                end
            end
            TURN: begin
                if (turn_cnt_q >= TURN_LAST) begin
                    if (target_q == OWNER_NMT) begin
                        state_d = nmt_req_valid ? NMT_OWN : IDLE;
                    end else begin
                        state_d = host_req_valid ? HOST_OWN : IDLE;
                    end
                    if (state_d != IDLE) begin
                        last_owner_d = target_q;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        nmt_seen_d = (state_q == NMT_OWN) && (state_d == NMT_OWN)
                   ? (nmt_seen_q | nmt_acc) : 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            target_q      <= OWNER_HOST;
            last_owner_q  <= OWNER_HOST;
            turn_cnt_q    <= '0;
            nmt_seen_q    <= 1'b0;
            last_nmt_wr_q <= 1'b0;
            cs_q          <= 1'b0;
            cmd_q         <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            last_owner_q  <= last_owner_d;
            turn_cnt_q    <= turn_cnt_d;
            nmt_seen_q    <= nmt_seen_d;
            last_nmt_wr_q <= last_nmt_wr_d;
            cs_q          <= cs_d;
            cmd_q         <= cmd_d;
        end
    end

    assign rank_cmd_valid = cmd_q.valid;
    assign rank_cmd_owner = cmd_q.owner;
    assign rank_cmd_write = cmd_q.write;
    assign context_switch = cs_q;

endmodule

// File: doc/rank_owner_arbiter.md
RANK_OWNER_ARBITER -- requirements
Module: rank_owner_arbiter

Interface
REQ-001 Parameter TURNAROUND_CYC, default 2: idle cycles inserted on every rank owner change; legal range 1..15.
REQ-002 Parameter STARVE_LIMIT, default 8: cycles a pending NMT request waits before it forces an owner switch; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port host_req_valid  input  1  host request pending.
REQ-006 Port host_req_op  input  1  host op: 0 READ, 1 WRITE.
REQ-007 Port host_req_ready  output  1  host request accepted this cycle when valid is also high.
REQ-008 Port nmt_req_valid  input  1  NMT request pending.
REQ-009 Port nmt_req_op  input  2  NMT op: 2'b00 WRITE, 2'b01 READ; 2'b10 and 2'b11 are treated as READ.
REQ-010 Port nmt_req_ready  output  1  NMT request accepted this cycle when valid is also high.
REQ-011 Port rank_busy  input  1  rank cannot take a command this cycle.
REQ-012 Port rank_cmd_valid  output  1  registered command to the rank.
REQ-013 Port rank_cmd_owner  output  1  owner of the command: 0 host, 1 NMT.
REQ-014 Port rank_cmd_write  output  1  1 for a write command.
REQ-015 Port context_switch  output  1  one-cycle predictor pulse.
REQ-016 Port starve_count  output  4  current NMT wait count.

Function
REQ-017 FSM states are IDLE, HOST_OWN, NMT_OWN and TURN; register last_owner holds the most recent owner.
REQ-018 host_req_ready = (state==HOST_OWN) & !rank_busy, and nmt_req_ready = (state==NMT_OWN) & !rank_busy; both ready outputs are 0 in IDLE and TURN.
REQ-019 An accept is valid&ready; rank_cmd_valid/owner/write are registered and appear exactly 1 cycle after the accept; rank_cmd_valid is 0 in all other cycles.
REQ-020 In IDLE, choose a target: NMT when nmt_req_valid and starve_count==STARVE_LIMIT; else host when host_req_valid; else NMT when nmt_req_valid; else stay in IDLE.
REQ-021 In IDLE, if the target equals last_owner, go directly to that owner's state; otherwise go to TURN with that target.
REQ-022 In HOST_OWN: if nmt_req_valid and starve_count==STARVE_LIMIT, go to TURN with target NMT (this takes priority over a pending host request); else if !host_req_valid and nmt_req_valid, go to TURN with target NMT; else if !host_req_valid, go to IDLE.
REQ-023 In NMT_OWN: if host_req_valid and at least one NMT accept has occurred since entry, go to TURN with target host; else if !nmt_req_valid, go to IDLE.
REQ-024 In TURN, count TURNAROUND_CYC cycles; rank_busy does not stall the count; then enter the target owner's state if its valid is high, else go to IDLE; last_owner updates on entry to an owner state.
REQ-025 context_switch pulses for exactly 1 cycle when NMT_OWN exits to TURN with target host, host_req_op==READ, and the last accepted NMT op was WRITE; it is 0 otherwise.
REQ-026 starve_count increments each cycle that nmt_req_valid is high and no NMT accept occurs, saturates at STARVE_LIMIT, and clears on an NMT accept or when nmt_req_valid is low.
REQ-027 When rank_busy is high, no accept occurs and the state holds, except that TURN continues counting and the starvation counter continues incrementing.

Reset
REQ-028 While rst_n is low at a clock edge: state is IDLE, last_owner is host, all outputs are 0, and the turnaround counter, starvation counter and last-NMT-op register are 0.
REQ-029 Reset asserted mid-TURN or mid-burst aborts the operation; no rank_cmd_valid is produced in the cycle after the reset edge.

Structure
REQ-030 Package rank_arb_pkg holds the state enum, host/NMT op encodings (NMT_WRITE=2'b00, NMT_READ=2'b01, HOST_READ=0, HOST_WRITE=1) and owner encoding (OWNER_HOST=0, OWNER_NMT=1).
REQ-031 The single sub-module is rank_starve_counter, a parameterized saturating counter with increment, clear and saturate-at-limit behaviour.

Verification
REQ-032 Scenario: after reset, host_req_valid=1 and op=READ for 3 cycles -> IDLE to HOST_OWN with no TURN; 3 accepts; rank_cmd_owner=0 and write=0 each 1 cycle later.
REQ-033 Scenario: host busy continuously and nmt_req_valid=1 -> starve_count reaches 8; TURN lasts 2 cycles with both readies 0; one NMT accept follows; starve_count becomes 0.
REQ-034 Scenario: NMT_OWN after accepting op 2'b00, then host_req_valid=1 with op=READ -> context_switch=1 for exactly 1 cycle; after TURN, host is granted. Repeat with host op=WRITE -> context_switch stays 0.
REQ-035 Scenario: rank_busy=1 for 4 cycles during HOST_OWN with both valids high -> no accepts, starve_count increments 4 times, state holds in HOST_OWN.
REQ-036 Scenario: drop nmt_req_valid during TURN targeting NMT -> FSM goes to IDLE after 2 cycles; no NMT accept occurs.
REQ-037 Scenario: assert rst_n=0 during TURN -> next cycle state is IDLE, all outputs are 0, and last_owner is host.
